// File: rtl/io_pkg.sv
// Shared definitions for the IN-instruction input path: FSM encoding, default widths
// and the switch zero-extension helper also used by the display/output path.
package io_pkg;

   localparam int SW_W_DEF   = 16;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_PRESS = 2'd1,
      ST_RELEASE    = 2'd2
   } state_e;

   function automatic logic [DATA_W_DEF-1:0] zext_sw(input logic [SW_W_DEF-1:0] sw);
      return {{(DATA_W_DEF-SW_W_DEF){1'b0}}, sw};
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for a raw push button; emits the
// debounced level and a registered one-cycle pulse on its 0->1 transition.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      // Any agreement with the accepted level restarts the stability window.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/io_input_handshake.sv
// Stalls the core on an IN request until a debounced confirm press, then captures the
// switches zero-extended and pulses io_valid for one cycle.
// Handshake: io_req is held high by the core until it sees io_valid; io_valid is a
// single-cycle pulse, and io_stall falls in that same cycle.
module io_input_handshake
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SW_W            = SW_W_DEF,
   parameter int DATA_W          = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [SW_W-1:0]   Switches,
   input  logic              confirm_button,
   input  logic              io_req,
   output logic [DATA_W-1:0] io_data,
   output logic              io_valid,
   output logic              io_stall,
   output logic              waiting_led,
   output state_e            dbg_state
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] io_data_q, io_data_d;
   logic              io_valid_q, io_valid_d;
   logic              btn_level;
   logic              btn_rise;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_confirm_db (
      .clk    (CLK),
      .rst    (reset),
      .btn_raw(confirm_button),
      .level  (btn_level),
      .rise   (btn_rise)
   );

   always_comb begin
      state_d    = state_q;
      io_data_d  = io_data_q;
      io_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io_req) state_d = ST_WAIT_PRESS;
         end
         ST_WAIT_PRESS: begin
            // A press already in progress at request time never produces a rise here.
            if (!io_req) begin
               state_d = ST_IDLE;
            end else if (btn_rise) begin
               io_data_d  = DATA_W'(zext_sw(SW_W_DEF'(Switches)));
               io_valid_d = 1'b1;
               state_d    = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!btn_level) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         io_data_q  <= '0;
         io_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         io_data_q  <= io_data_d;
         io_valid_q <= io_valid_d;
      end
   end

   assign io_data     = io_data_q;
   assign io_valid    = io_valid_q;
   // Reset gates the stall so the core is released the instant reset asserts.
   assign io_stall    = io_req & ~io_valid_q & ~reset;
   assign waiting_led = (state_q == ST_WAIT_PRESS);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_io_input_handshake.sv
// Directed bench for io_input_handshake with a short debounce window.
module tb_io_input_handshake;
   import io_pkg::*;

   localparam int DB = 4;
   localparam int PRESS_LAT = DB + 3;

   logic        CLK = 1'b0;
   logic        reset;
   logic [15:0] Switches;
   logic        confirm_button;
   logic        io_req;
   logic [31:0] io_data;
   logic        io_valid;
   logic        io_stall;
   logic        waiting_led;
   state_e      dbg_state;

   int checks = 0;
   int passes = 0;
   int valid_cnt = 0;
   int dbl_valid = 0;
   logic prev_valid = 1'b0;
   int lat;

   io_input_handshake #(
      .DEBOUNCE_CYCLES(DB),
      .SW_W(16),
      .DATA_W(32)
   ) dut (
      .CLK           (CLK),
      .reset         (reset),
      .Switches      (Switches),
      .confirm_button(confirm_button),
      .io_req        (io_req),
      .io_data       (io_data),
      .io_valid      (io_valid),
      .io_stall      (io_stall),
      .waiting_led   (waiting_led),
      .dbg_state     (dbg_state)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (io_valid) valid_cnt++;
      if (io_valid && prev_valid) dbl_valid++;
      prev_valid = io_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Ticks until io_valid (bounded); stall must stay high on every waiting cycle.
   task automatic wait_valid(input string tag, input int max, output int cyc);
      cyc = 0;
      for (int i = 1; i <= max; i++) begin
         tick(1);
         cyc = i;
         if (io_valid) break;
         check({tag, "_stall_wait"}, 32'(io_stall), 32'd1);
      end
      check({tag, "_valid_seen"}, 32'(io_valid), 32'd1);
      check({tag, "_stall_drop"}, 32'(io_stall), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      Switches = '0;
      confirm_button = 1'b0;
      io_req = 1'b0;
      #1;
      check("rst_data", io_data, 32'h0);
      check("rst_valid", 32'(io_valid), 32'd0);
      check("rst_stall", 32'(io_stall), 32'd0);
      check("rst_led", 32'(waiting_led), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick(3);
      reset = 1'b0;
      tick(2);

      // 1: basic request
      Switches = 16'h00A5;
      io_req = 1'b1;
      #1;
      check("t1_stall_req", 32'(io_stall), 32'd1);
      tick(1);
      check("t1_led", 32'(waiting_led), 32'd1);
      tick(9);
      confirm_button = 1'b1;
      wait_valid("t1", 20, lat);
      check("t1_latency", 32'(lat), 32'(PRESS_LAT));
      check("t1_data", io_data, 32'h000000A5);
      io_req = 1'b0;
      tick(1);
      check("t1_valid_pulse", 32'(io_valid), 32'd0);
      check("t1_release_state", 32'(dbg_state), 32'(ST_RELEASE));
      tick(4);
      confirm_button = 1'b0;
      tick(PRESS_LAT);
      check("t1_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("t1_count", 32'(valid_cnt), 32'd1);

      // 2: bouncing button
      Switches = 16'h003C;
      io_req = 1'b1;
      tick(2);
      for (int i = 0; i < 10; i++) begin
         confirm_button = ~confirm_button;
         tick(2);
      end
      check("t2_no_valid_bounce", 32'(valid_cnt), 32'd1);
      check("t2_led_bounce", 32'(waiting_led), 32'd1);
      confirm_button = 1'b1;
      wait_valid("t2", 20, lat);
      check("t2_latency", 32'(lat), 32'(PRESS_LAT));
      check("t2_data", io_data, 32'h0000003C);
      io_req = 1'b0;
      tick(1);
      check("t2_count", 32'(valid_cnt), 32'd2);
      confirm_button = 1'b0;
      tick(PRESS_LAT + 1);
      check("t2_idle", 32'(dbg_state), 32'(ST_IDLE));

      // 3: button held before the request
      confirm_button = 1'b1;
      tick(PRESS_LAT + 1);
      Switches = 16'h005A;
      io_req = 1'b1;
      tick(15);
      check("t3_no_valid_held", 32'(valid_cnt), 32'd2);
      check("t3_led_held", 32'(waiting_led), 32'd1);
      check("t3_stall_held", 32'(io_stall), 32'd1);
      confirm_button = 1'b0;
      tick(PRESS_LAT + 1);
      check("t3_no_valid_release", 32'(valid_cnt), 32'd2);
      confirm_button = 1'b1;
      wait_valid("t3", 20, lat);
      check("t3_latency", 32'(lat), 32'(PRESS_LAT));
      check("t3_data", io_data, 32'h0000005A);
      io_req = 1'b0;
      tick(1);
      check("t3_count", 32'(valid_cnt), 32'd3);
      confirm_button = 1'b0;
      tick(PRESS_LAT + 1);

      // 4a: abort in WAIT_PRESS
      Switches = 16'h0077;
      io_req = 1'b1;
      tick(3);
      check("t4_led", 32'(waiting_led), 32'd1);
      confirm_button = 1'b1;
      tick(3);
      io_req = 1'b0;
      confirm_button = 1'b0;
      tick(1);
      check("t4_abort_state", 32'(dbg_state), 32'(ST_IDLE));
      check("t4_abort_led", 32'(waiting_led), 32'd0);
      tick(10);
      check("t4_abort_count", 32'(valid_cnt), 32'd3);
      check("t4_abort_data", io_data, 32'h0000005A);

      // 4b: reset in WAIT_PRESS
      io_req = 1'b1;
      tick(3);
      check("t4_led2", 32'(waiting_led), 32'd1);
      reset = 1'b1;
      #1;
      check("t4_rst_stall", 32'(io_stall), 32'd0);
      check("t4_rst_led", 32'(waiting_led), 32'd0);
      check("t4_rst_valid", 32'(io_valid), 32'd0);
      check("t4_rst_data", io_data, 32'h0);
      check("t4_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick(2);
      reset = 1'b0;
      #1;
      check("t4_stall_after_rst", 32'(io_stall), 32'd1);
      tick(2);
      check("t4_led_after_rst", 32'(waiting_led), 32'd1);
      check("t4_rst_count", 32'(valid_cnt), 32'd3);
      io_req = 1'b0;
      tick(2);

      // 5: back-to-back requests with the button still held
      Switches = 16'h1234;
      io_req = 1'b1;
      tick(2);
      confirm_button = 1'b1;
      wait_valid("t5a", 20, lat);
      check("t5a_data", io_data, 32'h00001234);
      io_req = 1'b0;
      tick(1);
      io_req = 1'b1;
      Switches = 16'hFFFF;
      tick(1);
      check("t5_stall_held", 32'(io_stall), 32'd1);
      check("t5_release_state", 32'(dbg_state), 32'(ST_RELEASE));
      tick(10);
      check("t5_no_capture", io_data, 32'h00001234);
      check("t5_count_held", 32'(valid_cnt), 32'd4);
      check("t5_stall_still", 32'(io_stall), 32'd1);
      confirm_button = 1'b0;
      tick(PRESS_LAT + 3);
      check("t5_wait_state", 32'(dbg_state), 32'(ST_WAIT_PRESS));
      confirm_button = 1'b1;
      wait_valid("t5b", 20, lat);
      check("t5b_latency", 32'(lat), 32'(PRESS_LAT));
      check("t5b_data", io_data, 32'h0000FFFF);
      io_req = 1'b0;
      tick(1);
      confirm_button = 1'b0;
      Switches = 16'h0001;
      tick(PRESS_LAT + 1);
      check("t5_data_kept", io_data, 32'h0000FFFF);
      check("final_count", 32'(valid_cnt), 32'd5);
      check("no_double_valid", 32'(dbl_valid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
